// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: sequences one load/capture/unload pass over a mux-D scan chain
module scan_chain_ctrl #(
    parameter int CHAIN_LEN  = 32,
    parameter int CAP_CYCLES = 1,
    parameter int CNT_W      = 6
) (
    input  logic                 CK,
    input  logic                 RB,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic                 scan_so,
    output logic                 scan_sel,
    output logic                 scan_td,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [CHAIN_LEN-1:0] resp
);
    typedef enum logic [1:0] {IDLE, LOAD, CAPT, UNLOAD} state_t;
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CAPT_LAST  = CNT_W'(CAP_CYCLES - 1);
    state_t               state;
    logic [CHAIN_LEN-1:0] pat_sr;
    logic [CNT_W-1:0]     cnt;
    // pat_sr holds the bits still to be driven; scan_td is registered one bit ahead
    always_ff @(posedge CK or negedge RB) begin
        if (!RB) begin
            state    <= IDLE;
            scan_sel <= 1'b0;
            scan_td  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            resp     <= '0;
            pat_sr   <= '0;
            cnt      <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            if (abort && state != IDLE) begin
                state    <= IDLE;
                scan_sel <= 1'b0;
                scan_td  <= 1'b0;
                busy     <= 1'b0;
                aborted  <= 1'b1;
                cnt      <= '0;
            end else begin
                case (state)
                    IDLE: if (start && !abort) begin
                        pat_sr   <= pattern >> 1;
                        scan_td  <= pattern[0];
                        scan_sel <= 1'b1;
                        busy     <= 1'b1;
                        resp     <= '0;
                        cnt      <= '0;
                        state    <= LOAD;
                    end
                    LOAD: begin
                        pat_sr <= pat_sr >> 1;
                        if (cnt == SHIFT_LAST) begin
                            cnt      <= '0;
                            scan_sel <= 1'b0;
                            scan_td  <= 1'b0;
                            state    <= CAPT;
                        end else begin
                            cnt     <= cnt + 1'b1;
                            scan_td <= pat_sr[0];
                        end
                    end
                    CAPT: if (cnt == CAPT_LAST) begin
                        cnt      <= '0;
                        scan_sel <= 1'b1;
                        state    <= UNLOAD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    UNLOAD: begin
                        resp <= {scan_so, resp[CHAIN_LEN-1:1]};
                        if (cnt == SHIFT_LAST) begin
                            cnt      <= '0;
                            scan_sel <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: two controller configs driving behavioural scan chains, checked against pass-level expectations
module tb_scan_chain_ctrl;
    logic clk = 1'b0, rb = 1'b1, start = 1'b0, abort = 1'b0, inv = 1'b0, sel_i = 1'b0;
    logic [31:0] pattern = '0;
    int tests = 0, fails = 0;
    always #5 clk = ~clk;

    logic a_sel, a_td, a_busy, a_done, a_ab;
    logic [7:0] a_resp;
    logic [7:0] chain_a = '0;
    logic b_sel, b_td, b_busy, b_done, b_ab;
    logic [31:0] b_resp;
    logic [31:0] chain_b = '0;

    scan_chain_ctrl #(.CHAIN_LEN(8), .CAP_CYCLES(1), .CNT_W(4)) u_a (
        .CK(clk), .RB(rb), .start(start && !sel_i), .abort(abort && !sel_i),
        .pattern(pattern[7:0]), .scan_so(chain_a[0]), .scan_sel(a_sel), .scan_td(a_td),
        .busy(a_busy), .done(a_done), .aborted(a_ab), .resp(a_resp));
    scan_chain_ctrl #(.CHAIN_LEN(32), .CAP_CYCLES(3), .CNT_W(6)) u_b (
        .CK(clk), .RB(rb), .start(start && sel_i), .abort(abort && sel_i),
        .pattern(pattern), .scan_so(chain_b[0]), .scan_sel(b_sel), .scan_td(b_td),
        .busy(b_busy), .done(b_done), .aborted(b_ab), .resp(b_resp));

    // chain: TD enters the top cell, bit 0 drives scan_so; capture holds or inverts Q
    always @(posedge clk) chain_a <= a_sel ? {a_td, chain_a[7:1]} : (inv ? ~chain_a : chain_a);
    always @(posedge clk) chain_b <= b_sel ? {b_td, chain_b[31:1]} : (inv ? ~chain_b : chain_b);

    logic m_sel, m_td, m_busy, m_done, m_ab;
    logic [31:0] m_resp;
    assign m_sel  = sel_i ? b_sel  : a_sel;
    assign m_td   = sel_i ? b_td   : a_td;
    assign m_busy = sel_i ? b_busy : a_busy;
    assign m_done = sel_i ? b_done : a_done;
    assign m_ab   = sel_i ? b_ab   : a_ab;
    assign m_resp = sel_i ? b_resp : {24'b0, a_resp};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one full pass; returns on the negedge where done is seen so a follow-up start lands in the done cycle
    task automatic run_pass(input logic [31:0] pat, input bit iv, input int repulse);
        int len, cap, lat, n, busy_n, low_n;
        logic [31:0] exp;
        len = sel_i ? 32 : 8;
        cap = sel_i ? 3 : 1;
        lat = 2 * len + cap;
        exp = (iv && cap % 2 == 1) ? ~pat : pat;
        if (len < 32) exp &= (32'd1 << len) - 1;
        pattern = pat;
        inv = iv;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0; busy_n = 0; low_n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("first_sel", m_sel, 1);
                check("first_td", m_td, pat[0]);
                check("done_low", m_done, 0);
            end
            start = (n == repulse);
            busy_n += int'(m_busy);
            low_n += int'(m_busy && !m_sel);
        end while (!m_done && n < lat + 20);
        start = 1'b0;
        check("latency", n, lat + 1);
        check("busy_cycles", busy_n, lat);
        check("sel_low", low_n, cap);
        check("resp", m_resp, exp);
        check("busy_at_done", m_busy, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sel"}, m_sel, 0);
        check({tag, "_td"}, m_td, 0);
        check({tag, "_busy"}, m_busy, 0);
        check({tag, "_done"}, m_done, 0);
        check({tag, "_aborted"}, m_ab, 0);
    endtask

    initial begin
        #2 rb = 1'b0;
        #1 check_zero("reset");
        check("reset_resp", m_resp, 0);
        repeat (2) @(negedge clk);
        rb = 1'b1;
        @(negedge clk);
        // T1 loopback, T2 inverting capture
        run_pass(32'hA5, 1'b0, 0);
        @(negedge clk);
        run_pass(32'h3C, 1'b1, 0);
        @(negedge clk);
        // T3 abort on LOAD cycle 4
        pattern = 32'h5A;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_sel", m_sel, 0);
        check("abort_busy", m_busy, 0);
        check("abort_pulse", m_ab, 1);
        check("abort_done", m_done, 0);
        @(negedge clk);
        check("abort_pulse_end", m_ab, 0);
        check("abort_no_done", m_done, 0);
        run_pass(32'hA5, 1'b0, 0);
        @(negedge clk);
        // abort in IDLE does nothing
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_pulse", m_ab, 0);
        check("idle_abort_busy", m_busy, 0);
        // T4 start during UNLOAD ignored, then start in the done cycle
        run_pass(32'hC7, 1'b0, 12);
        run_pass(32'h1E, 1'b1, 0);
        run_pass(32'h81, 1'b0, 0);
        @(negedge clk);
        // T5 reset during CAPT
        pattern = 32'hFF;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rb = 1'b0;
        #1 check_zero("midreset");
        check("midreset_resp", m_resp, 0);
        @(negedge clk);
        rb = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_busy", m_busy, 0);
        check("post_reset_sel", m_sel, 0);
        for (int i = 0; i < 6; i++) begin
            run_pass($urandom(), 1'($urandom_range(0, 1)), 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        // T6 wide chain, three capture cycles
        @(negedge clk);
        sel_i = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            run_pass($urandom(), 1'($urandom_range(0, 1)), 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
